xnor_match_arb: RTL and testbench

XNOR_MATCH_ARB -- requirements
Module: xnor_match_arb

---
 rtl/xnor_match_arb.sv | 107 ++++++++++
 tb/tb_xnor_match_arb.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/xnor_match_arb.sv
// Two-requester bit-serial XNOR match counter: 10 cycles/op, gnt->done 8 cycles; requests wait in IDLE until granted.
// Define XNOR_MATCH_RR_EN for round-robin contention; otherwise req[0] has fixed priority.
module xnor_match_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [7:0] a0,
  input  logic [7:0] b0,
  input  logic [7:0] a1,
  input  logic [7:0] b1,
  output logic [1:0] gnt,
  output logic       busy,
  output logic       done,
  output logic       done_id,
  output logic [3:0] match_cnt,
  output logic       all_eq
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0] state;
  logic [7:0] a_sh;
  logic [7:0] b_sh;
  logic [2:0] k;
  logic [3:0] acc;
  logic [3:0] acc_next;
  logic       cur_id;
  logic       win_id;
  logic       bit_eq;

`ifdef XNOR_MATCH_RR_EN
  logic last_id;

  // On contention the requester not served last wins; reset makes requester 0 next.
  always_comb win_id = (req == 2'b11) ? ~last_id : ~req[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_id <= 1'b1;
    end else if (state == IDLE && req != 2'b00) begin
      last_id <= win_id;
    end
  end
`else
  always_comb win_id = ~req[0];
`endif

  // Single XNOR per cycle on the LSBs of the captured operands.
  assign bit_eq   = ~(a_sh[0] ^ b_sh[0]);
  assign acc_next = acc + {3'b000, bit_eq};
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a_sh      <= 8'h00;
      b_sh      <= 8'h00;
      k         <= 3'd0;
      acc       <= 4'd0;
      cur_id    <= 1'b0;
      gnt       <= 2'b00;
      done      <= 1'b0;
      done_id   <= 1'b0;
      match_cnt <= 4'd0;
      all_eq    <= 1'b0;
    end else begin
      gnt <= 2'b00;
      case (state)
        IDLE: begin
          if (req != 2'b00) begin
            a_sh   <= win_id ? a1 : a0;
            b_sh   <= win_id ? b1 : b0;
            gnt    <= win_id ? 2'b10 : 2'b01;
            cur_id <= win_id;
            k      <= 3'd0;
            acc    <= 4'd0;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          a_sh <= {1'b0, a_sh[7:1]};
          b_sh <= {1'b0, b_sh[7:1]};
          acc  <= acc_next;
          k    <= k + 3'd1;
          if (k == 3'd7) begin
            match_cnt <= acc_next;
            all_eq    <= (acc_next == 4'd8);
            done_id   <= cur_id;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xnor_match_arb.sv
// Randomized and directed bench for xnor_match_arb against a popcount/arbitration reference model.
module tb_xnor_match_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [7:0] a0, b0, a1, b1;
  logic [1:0] gnt;
  logic       busy, done, done_id, all_eq;
  logic [3:0] match_cnt;

  int checks = 0;
  int errors = 0;
  logic tb_last;  // id granted most recently (1 after reset so 0 is favoured)

  xnor_match_arb dut (
    .clk(clk), .rst(rst), .req(req),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt(gnt), .busy(busy), .done(done), .done_id(done_id),
    .match_cnt(match_cnt), .all_eq(all_eq)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] ref_count(input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    for (int i = 0; i < 8; i++) if (a[i] == b[i]) n++;
    return 4'(n);
  endfunction

  function automatic logic [1:0] ref_gnt(input logic [1:0] r, input logic last);
    if (r == 2'b01) return 2'b01;
    if (r == 2'b10) return 2'b10;
`ifdef XNOR_MATCH_RR_EN
    return last ? 2'b01 : 2'b10;
`else
    return 2'b01;
`endif
  endfunction

  // Runs one operation starting at the next edge; reports observations only.
  task automatic run_op(input logic [1:0] r, input logic [7:0] va0, input logic [7:0] vb0,
                        input logic [7:0] va1, input logic [7:0] vb1, input bit keep, input bit scramble,
                        output logic [1:0] g, output logic bsy, output int lat, output int stray,
                        output logic [3:0] mc, output logic ae, output logic did);
    @(negedge clk);
    req = r; a0 = va0; b0 = vb0; a1 = va1; b1 = vb1;
    @(posedge clk); #1;
    g = gnt; bsy = busy;
    if (!keep) req = req & ~g;
    if (scramble) begin
      a0 = 8'($urandom_range(255)); b0 = 8'($urandom_range(255));
      a1 = 8'($urandom_range(255)); b1 = 8'($urandom_range(255));
    end
    lat = -1; stray = 0;
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      @(posedge clk); #1;
      if (gnt !== 2'b00) stray++;
      if (done === 1'b1) lat = i;
    end
    mc = match_cnt; ae = all_eq; did = done_id;
    @(posedge clk); #1;
    if (done !== 1'b0 || busy !== 1'b0) stray++;
  endtask

  task automatic test_reset;
    rst = 1'b1; req = 2'b00; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    #1;
    checks++;
    if ({gnt, busy, done, done_id, match_cnt, all_eq} !== 10'd0) begin
      errors++; $display("FAIL reset_outputs got %b want 0", {gnt, busy, done, done_id, match_cnt, all_eq});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tb_last = 1'b1;
  endtask

  task automatic test_basic;
    logic [1:0] g; logic bsy, ae, did; int lat, stray; logic [3:0] mc;
    run_op(2'b01, 8'hA5, 8'hA5, 8'h00, 8'h00, 0, 0, g, bsy, lat, stray, mc, ae, did);
    tb_last = 1'b0;
    checks++; if (g !== 2'b01) begin errors++; $display("FAIL basic_gnt got %b want 01", g); end
    checks++; if (bsy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b want 1", bsy); end
    checks++; if (lat != 8) begin errors++; $display("FAIL basic_latency got %0d want 8", lat); end
    checks++; if (mc !== 4'd8 || ae !== 1'b1 || did !== 1'b0) begin
      errors++; $display("FAIL basic_result got cnt=%0d eq=%b id=%b want 8 1 0", mc, ae, did); end
    checks++; if (stray != 0) begin errors++; $display("FAIL basic_pulses got %0d stray want 0", stray); end
  endtask

  task automatic test_operand_change;
    logic [1:0] g; logic bsy, ae, did; int lat, stray; logic [3:0] mc;
    run_op(2'b10, 8'h00, 8'h00, 8'hFF, 8'h0F, 0, 1, g, bsy, lat, stray, mc, ae, did);
    tb_last = 1'b1;
    checks++; if (g !== 2'b10) begin errors++; $display("FAIL opchg_gnt got %b want 10", g); end
    checks++; if (lat != 8) begin errors++; $display("FAIL opchg_latency got %0d want 8", lat); end
    checks++; if (mc !== 4'd4 || ae !== 1'b0 || did !== 1'b1) begin
      errors++; $display("FAIL opchg_result got cnt=%0d eq=%b id=%b want 4 0 1", mc, ae, did); end
  endtask

  task automatic test_contention;
    logic [1:0] g; logic bsy, ae, did; int lat, stray; logic [3:0] mc;
`ifdef XNOR_MATCH_RR_EN
    logic [1:0] order [3] = '{2'b01, 2'b10, 2'b01};
`else
    logic [1:0] order [3] = '{2'b01, 2'b01, 2'b01};
`endif
    for (int n = 0; n < 3; n++) begin
      logic [7:0] x = 8'($urandom_range(255));
      logic [7:0] y = 8'($urandom_range(255));
      run_op(2'b11, x, y, y, x ^ 8'h3C, 1, 0, g, bsy, lat, stray, mc, ae, did);
      checks++;
      if (g !== order[n]) begin errors++; $display("FAIL contention_order op%0d got %b want %b", n, g, order[n]); end
      checks++;
      if (mc !== (order[n][1] ? ref_count(y, x ^ 8'h3C) : ref_count(x, y)) || did !== order[n][1]) begin
        errors++; $display("FAIL contention_result op%0d got cnt=%0d id=%b", n, mc, did); end
      tb_last = order[n][1];
    end
    @(negedge clk); req = 2'b00;
  endtask

  task automatic test_shift_req;
    int bad = 0;
    @(negedge clk); req = 2'b01; a0 = 8'h00; b0 = 8'hFF;
    @(posedge clk); #1;
    checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL shiftreq_gnt0 got %b want 01", gnt); end
    tb_last = 1'b0;
    @(negedge clk); req = 2'b10;
    for (int e = 1; e <= 9; e++) begin
      @(posedge clk); #1;
      if (gnt !== 2'b00) bad++;
      if (e == 8) begin
        checks++;
        if (done !== 1'b1 || match_cnt !== 4'd0 || all_eq !== 1'b0) begin
          errors++; $display("FAIL shiftreq_result got done=%b cnt=%0d want 1 0", done, match_cnt); end
      end
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL shiftreq_early_gnt got %0d cycles want 0", bad); end
    @(posedge clk); #1;
    checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL shiftreq_e10 got %b want 10", gnt); end
    tb_last = 1'b1;
    req = 2'b00;
    repeat (10) @(posedge clk);
  endtask

  task automatic test_reset_mid;
    int dones = 0;
    @(negedge clk); req = 2'b01; a0 = 8'($urandom_range(255)); b0 = 8'($urandom_range(255));
    @(posedge clk); #1;
    checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL rstmid_gnt got %b want 01", gnt); end
    req = 2'b00;
    repeat (4) @(posedge clk);
    #1; rst = 1'b1; req = 2'b10;
    #1;
    checks++;
    if ({gnt, busy, done, done_id, match_cnt, all_eq} !== 10'd0) begin
      errors++; $display("FAIL rstmid_outputs got %b want 0", {gnt, busy, done, done_id, match_cnt, all_eq}); end
    repeat (3) begin @(posedge clk); #1; if (done !== 1'b0) dones++; end
    tb_last = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int e = 0; e < 12; e++) begin @(posedge clk); #1; if (done === 1'b1 && e < 8) dones++; if (e == 0) begin
      checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL rstmid_resume got %b want 10", gnt); end
      req = 2'b00; end
    end
    checks++; if (dones != 0) begin errors++; $display("FAIL rstmid_no_done got %0d early dones want 0", dones); end
    tb_last = 1'b1;
  endtask

  task automatic test_random;
    logic [1:0] g, eg; logic bsy, ae, did; int lat, stray; logic [3:0] mc, em;
    for (int n = 0; n < 24; n++) begin
      logic [1:0] r = 2'($urandom_range(3, 1));
      logic [7:0] x0 = 8'($urandom_range(255)), y0 = 8'($urandom_range(255));
      logic [7:0] x1 = 8'($urandom_range(255)), y1 = 8'($urandom_range(255));
      if (n % 4 == 0) y0 = x0;
      eg = ref_gnt(r, tb_last);
      em = eg[1] ? ref_count(x1, y1) : ref_count(x0, y0);
      run_op(r, x0, y0, x1, y1, 0, n % 2 == 1, g, bsy, lat, stray, mc, ae, did);
      tb_last = eg[1];
      checks++;
      if (g !== eg || lat != 8 || stray != 0) begin
        errors++; $display("FAIL rand_ctrl op%0d got gnt=%b lat=%0d stray=%0d want %b 8 0", n, g, lat, stray, eg); end
      checks++;
      if (mc !== em || ae !== (em == 4'd8) || did !== eg[1]) begin
        errors++; $display("FAIL rand_result op%0d got cnt=%0d eq=%b id=%b want %0d %b %b", n, mc, ae, did, em, em == 4'd8, eg[1]); end
    end
    @(negedge clk); req = 2'b00;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_operand_change;
    test_contention;
    test_shift_req;
    test_reset_mid;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
